// File: rtl/tod_pkg.sv
// tod_pkg: shared encodings and limits for the time-of-day set controller.
//   mode_e       : set-mode FSM states, encoded exactly as driven on the mode port
//   HOUR_W/MS_W  : field widths for hour and minute/second
//   MAX_HOUR     : last legal hour value before wrapping to 0
//   MAX_MIN_SEC  : last legal minute/second value before wrapping to 0
package tod_pkg;

    localparam int HOUR_W = 5;
    localparam int MS_W   = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR    = 5'd23;
    localparam logic [MS_W-1:0]   MAX_MIN_SEC = 6'd59;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_SEC  = 2'b11
    } mode_e;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and edge-detect one active-low pushbutton.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (key reads as released afterwards)
//   key_n  in  raw pushbutton level, active-low, asynchronous to clk
//   press  out one-cycle pulse when the debounced level goes released -> pressed
module key_debounce
    import tod_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1, sync2;
    logic             level, level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // cnt holds the number of consecutive disagreeing samples seen so far;
    // the level flips on the DEBOUNCE_CYC-th one. Any agreement starts over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            level   <= 1'b1;
            level_d <= 1'b1;
        end else begin
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level_d & ~level;

endmodule

// File: rtl/tod_set_controller.sv
// tod_set_controller: 1 Hz enable, pushbutton set-mode FSM, shadow time
// registers and blink masks for the time-of-day clock.
//   clk, rst_n            clock, asynchronous active-low reset
//   key_mode_n, key_inc_n raw active-low pushbuttons (advance mode / increment field)
//   cur_hour/min/sec      live time from the datapath, captured on entry to set mode
//   tick_1hz              one-cycle count enable, only ever high in RUN
//   load                  one-cycle strobe leaving SET_SEC; datapath takes load_*
//   load_hour/min/sec     shadow time, shown continuously
//   mode                  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blank_mask            {hour,min,sec}: 1 blanks that field this cycle
module tod_set_controller
    import tod_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_mode_n,
    input  logic              key_inc_n,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MS_W-1:0]   cur_min,
    input  logic [MS_W-1:0]   cur_sec,
    output logic              tick_1hz,
    output logic              load,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MS_W-1:0]   load_min,
    output logic [MS_W-1:0]   load_sec,
    output logic [1:0]        mode,
    output logic [2:0]        blank_mask
);

    localparam int               PRE_W     = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam int               BLINK_CYC = CLK_HZ / 4;
    localparam int               BLK_W     = $clog2(BLINK_CYC + 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_CYC - 1);

    mode_e              state, state_nxt;
    logic               press_mode, press_inc, inc_ok;
    logic [PRE_W-1:0]   pre_cnt;
    logic [BLK_W-1:0]   blk_cnt;
    logic               blink_phase;
    logic [HOUR_W-1:0]  sh_hour;
    logic [MS_W-1:0]    sh_min, sh_sec;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_mode_n),
        .press (press_mode)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_inc_n),
        .press (press_inc)
    );

    // A mode press in the same cycle swallows the increment.
    assign inc_ok = press_inc & ~press_mode & (state != MODE_RUN);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MODE_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (press_mode) begin
            case (state)
                MODE_RUN:      state_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: state_nxt = MODE_SET_MIN;
                MODE_SET_MIN:  state_nxt = MODE_SET_SEC;
                default:       state_nxt = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        mode       = state;
        tick_1hz   = (state == MODE_RUN) && (pre_cnt == PRE_LAST);
        blank_mask = 3'b000;
        if (blink_phase) begin
            case (state)
                MODE_SET_HOUR: blank_mask = 3'b100;
                MODE_SET_MIN:  blank_mask = 3'b010;
                MODE_SET_SEC:  blank_mask = 3'b001;
                default:       blank_mask = 3'b000;
            endcase
        end
    end

    // Load goes out in the cycle after the leaving press, when mode already reads RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) load <= 1'b0;
        else        load <= press_mode && (state == MODE_SET_SEC);
    end

    // ---------------- prescaler ----------------
    // Also held through the load cycle so the first tick lands a full
    // CLK_HZ cycles after the datapath takes the new time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          pre_cnt <= '0;
        else if (state != MODE_RUN || load)  pre_cnt <= '0;
        else if (pre_cnt == PRE_LAST)        pre_cnt <= '0;
        else                                 pre_cnt <= pre_cnt + 1'b1;
    end

    // ---------------- blink divider ----------------
    // Restarts visible on any state change or accepted increment so the
    // field being edited is on screen right after the user touches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (press_mode || inc_ok || state == MODE_RUN) begin
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (blk_cnt == BLK_LAST) begin
            blk_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // ---------------- shadow registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hour <= '0;
            sh_min  <= '0;
            sh_sec  <= '0;
        end else if (press_mode && state == MODE_RUN) begin
            sh_hour <= cur_hour;
            sh_min  <= cur_min;
            sh_sec  <= cur_sec;
        end else if (inc_ok) begin
            case (state)
                MODE_SET_HOUR: sh_hour <= (sh_hour == MAX_HOUR)    ? '0 : sh_hour + 1'b1;
                MODE_SET_MIN:  sh_min  <= (sh_min  == MAX_MIN_SEC) ? '0 : sh_min  + 1'b1;
                MODE_SET_SEC:  sh_sec  <= (sh_sec  == MAX_MIN_SEC) ? '0 : sh_sec  + 1'b1;
                default:       ;
            endcase
        end
    end

    assign load_hour = sh_hour;
    assign load_min  = sh_min;
    assign load_sec  = sh_sec;

endmodule

// File: tb/tb_tod_set_controller.sv
// Bench for tod_set_controller (CLK_HZ=20, DEBOUNCE_CYC=4). A cycle-level
// behavioural model predicts every output; directed sequences add literal
// expectations for tick spacing, key filtering, wraps, load and blink.
module tb_tod_set_controller;

    localparam int CLK_HZ = 20;
    localparam int DB     = 4;
    localparam int BL     = CLK_HZ / 4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       key_inc_n  = 1'b1;
    logic [4:0] cur_hour   = 5'd12;
    logic [5:0] cur_min    = 6'd34;
    logic [5:0] cur_sec    = 6'd56;
    logic       tick_1hz, load;
    logic [4:0] load_hour;
    logic [5:0] load_min, load_sec;
    logic [1:0] mode;
    logic [2:0] blank_mask;

    int n_total = 0;
    int n_pass  = 0;

    tod_set_controller #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_mode_n (key_mode_n),
        .key_inc_n  (key_inc_n),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .tick_1hz   (tick_1hz),
        .load       (load),
        .load_hour  (load_hour),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .mode       (mode),
        .blank_mask (blank_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in clock edges since reset release (e_cnt). Ticks fall
    // every CLK_HZ edges from an anchor (release, or the end of a load cycle);
    // blink phase is (edges since last entry/increment)/BL, odd = blanked.
    int       m_mode, m_h, m_m, m_s, e_cnt, t_anchor, b_anchor;
    bit       m_load, lvl_m, lvl_i, pr_m, pr_i;
    bit [15:0] h_m, h_i;   // raw key history, bit j = value j edges ago

    task automatic m_reset();
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
        e_cnt = 0; t_anchor = 0; b_anchor = 0;
        m_load = 1'b0; lvl_m = 1'b1; lvl_i = 1'b1; pr_m = 1'b0; pr_i = 1'b0;
        h_m = '1; h_i = '1;
    endtask

    // Debounced level flips once DB consecutive synchronised samples
    // (raw delayed by two edges) all disagree with it.
    function automatic bit flips(input bit [15:0] h, input bit lvl);
        for (int j = 2; j < DB + 2; j++) if (h[j] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_step();
        bit was_load;
        was_load = m_load;
        e_cnt++;
        m_load = 1'b0;
        if (was_load) t_anchor = e_cnt;
        if (pr_m) begin
            if (m_mode == 0) begin
                m_h = int'(cur_hour); m_m = int'(cur_min); m_s = int'(cur_sec);
            end
            if (m_mode == 3) m_load = 1'b1;
            m_mode   = (m_mode + 1) % 4;
            b_anchor = e_cnt;
        end else if (pr_i && m_mode != 0) begin
            case (m_mode)
                1:       m_h = (m_h + 1) % 24;
                2:       m_m = (m_m + 1) % 60;
                default: m_s = (m_s + 1) % 60;
            endcase
            b_anchor = e_cnt;
        end
        h_m = {h_m[14:0], key_mode_n};
        h_i = {h_i[14:0], key_inc_n};
        pr_m = 1'b0;
        if (flips(h_m, lvl_m)) begin pr_m = lvl_m; lvl_m = ~lvl_m; end
        pr_i = 1'b0;
        if (flips(h_i, lvl_i)) begin pr_i = lvl_i; lvl_i = ~lvl_i; end
    endtask

    function automatic logic exp_tick();
        return (m_mode == 0) && !m_load && ((e_cnt - t_anchor) % CLK_HZ == CLK_HZ - 1);
    endfunction

    function automatic logic [2:0] exp_blank();
        int sel;
        if (m_mode == 0) return 3'b000;
        sel = (m_mode == 1) ? 4 : (m_mode == 2) ? 2 : 1;
        return (((e_cnt - b_anchor) / BL) % 2 == 1) ? 3'(sel) : 3'b000;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n)
            check("cycle", 32'({mode, load, tick_1hz, blank_mask, load_hour, load_min, load_sec}),
                  32'({2'(m_mode), m_load, exp_tick(), exp_blank(), 5'(m_h), 6'(m_m), 6'(m_s)}));
    end

    task automatic press(input bit pm, input bit pi);
        @(negedge clk);
        if (pm) key_mode_n = 1'b0;
        if (pi) key_inc_n  = 1'b0;
        repeat (10) @(negedge clk);
        key_mode_n = 1'b1;
        key_inc_n  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int        t_pos[3];
        int        n_t, loads, got, wait_n;
        logic [19:0] blink_pat;
        t_pos = '{-1, -1, -1};
        n_t = 0; loads = 0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'({mode, load, tick_1hz, blank_mask}), 32'h0);
        check("rst_shadow", 32'({load_hour, load_min, load_sec}), 32'h0);
        rst_n = 1'b1;

        // 1: i counts edges since release; the tick seen after edge 19 is
        // consumed by the datapath on edge 20 (cycles 20, 40, 60).
        for (int i = 1; i <= 62; i++) begin
            @(negedge clk);
            if (tick_1hz) begin
                if (n_t < 3) t_pos[n_t] = i;
                n_t++;
            end
            if (load) loads++;
        end
        check("tick_count", 32'(n_t), 32'd3);
        check("tick_1st", 32'(t_pos[0]), 32'd19);
        check("tick_2nd", 32'(t_pos[1]), 32'd39);
        check("tick_3rd", 32'(t_pos[2]), 32'd59);
        check("no_load_run", 32'(loads), 32'd0);

        // 2: short glitch filtered, long hold gives exactly one press
        @(negedge clk); key_mode_n = 1'b0;
        repeat (2) @(negedge clk); key_mode_n = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_mode", 32'(mode), 32'd0);
        press(1'b1, 1'b0);
        check("one_press_mode", 32'(mode), 32'd1);
        check("capture", 32'({load_hour, load_min, load_sec}), 32'({5'd12, 6'd34, 6'd56}));

        // 3: wraps without carry, then a single load and tick 20 cycles later
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
        check("back_run", 32'(mode), 32'd0);
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd58;
        press(1'b1, 1'b0);
        check("capture2", 32'({load_hour, load_min, load_sec}), 32'({5'd23, 6'd59, 6'd58}));
        press(1'b0, 1'b1);
        check("hour_wrap", 32'({load_hour, load_min, load_sec}), 32'({5'd0, 6'd59, 6'd58}));
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("min_wrap", 32'({load_hour, load_min, load_sec}), 32'({5'd0, 6'd0, 6'd58}));
        press(1'b1, 1'b0);
        check("in_set_sec", 32'(mode), 32'd3);
        @(negedge clk); key_mode_n = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (load) got = 1;
        end
        check("load_seen", 32'(got), 32'd1);
        check("load_vals", 32'({load_hour, load_min, load_sec}), 32'({5'd0, 6'd0, 6'd58}));
        check("load_mode", 32'(mode), 32'd0);
        key_mode_n = 1'b1;
        wait_n = 0; loads = 0;
        for (int i = 1; i <= 30 && wait_n == 0; i++) begin
            @(negedge clk);
            if (load) loads++;
            if (tick_1hz) wait_n = i;
        end
        check("tick_after_load", 32'(wait_n), 32'd20);
        check("single_load", 32'(loads), 32'd0);

        // 4: simultaneous presses in SET_MIN -> mode advances, min untouched
        cur_hour = 5'd5; cur_min = 6'd17; cur_sec = 6'd42;
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        check("in_set_min", 32'(mode), 32'd2);
        press(1'b1, 1'b1);
        check("both_mode", 32'(mode), 32'd3);
        check("both_min", 32'({load_hour, load_min}), 32'({5'd5, 6'd17}));

        // 6: reset in SET_SEC abandons the edit
        @(posedge clk); #3; rst_n = 1'b0; #1;
        check("rst_mid_state", 32'({mode, load, tick_1hz, blank_mask}), 32'h0);
        check("rst_mid_vals", 32'({load_hour, load_min, load_sec}), 32'h0);
        loads = 0;
        repeat (5) begin
            @(negedge clk);
            if (load) loads++;
        end
        check("rst_no_load", 32'(loads), 32'd0);
        rst_n = 1'b1;

        // 5: blink in SET_HOUR, visible first, 5 cycles per half period
        cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd59;
        @(negedge clk); key_mode_n = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (mode == 2'b01) got = 1;
        end
        check("enter_hour", 32'(got), 32'd1);
        blink_pat = 20'b11111_00000_11111_00000;
        for (int j = 0; j < 20; j++) begin
            check("blink", 32'(blank_mask), blink_pat[j] ? 32'd4 : 32'd0);
            @(negedge clk);
        end
        key_mode_n = 1'b1;
        repeat (10) @(negedge clk);
        press(1'b0, 1'b1);
        check("hour_inc", 32'(load_hour), 32'd11);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("sec_wrap", 32'({load_min, load_sec}), 32'({6'd20, 6'd0}));
        press(1'b1, 1'b0);
        check("run_blank", 32'({mode, blank_mask}), 32'h0);
        press(1'b0, 1'b1);
        check("run_inc_ignored", 32'({load_hour, load_min, load_sec}), 32'({5'd11, 6'd20, 6'd0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
